// File: rtl/tube_ph1_fifo.sv
`timescale 1ns/1ps
// tube_ph1_fifo: parasite-to-host byte FIFO behind Tube register 1 (PH1).
// Both asynchronous bus interfaces are sampled on clk; head byte and flags are registered.
module tube_ph1_fifo #(
  parameter int DEPTH = 24,
  parameter int PW    = 5
) (
  input  logic          clk,
  input  logic          h_rst_b,
  input  logic          fifo_clr,
  input  logic          p_cs_b,
  input  logic          p_wr_b,
  input  logic [2:0]    p_addr,
  input  logic [7:0]    p_data,
  input  logic          h_phi2,
  input  logic          h_cs_b,
  input  logic          h_rdnw,
  input  logic [2:0]    h_addr,
  output logic [7:0]    h_rd_data,
  output logic          ph1_avail,
  output logic          ph1_space,
  output logic [PW-1:0] ph1_count,
  output logic          ph1_ovf
);

  localparam logic [2:0]    RegPh1  = 3'b001;
  localparam logic [PW-1:0] LastIdx = PW'(DEPTH - 1);
  localparam logic [PW-1:0] FullCnt = PW'(DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  // Reset: asynchronous assert, deassert released through two flops.
  logic rst_meta_q, rst_b_q;

  // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge h_rst_b) begin
    if (!h_rst_b) begin
      rst_meta_q <= 1'b0;
      rst_b_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_b_q    <= rst_meta_q;
    end
  end

  // [0] first stage, [1] synchronized copy, [2] delayed copy for edge detection.
  logic [2:0] p_wr_sync_q;
  logic [2:0] phi2_sync_q;
  logic       p_wr_rise;
  logic       phi2_fall;

  always_ff @(posedge clk or negedge rst_b_q) begin
    if (!rst_b_q) begin
      p_wr_sync_q <= 3'b111;
      phi2_sync_q <= 3'b000;
    end else begin
      p_wr_sync_q <= {p_wr_sync_q[1:0], p_wr_b};
      phi2_sync_q <= {phi2_sync_q[1:0], h_phi2};
    end
  end

  assign p_wr_rise = p_wr_sync_q[1] & ~p_wr_sync_q[2];
  assign phi2_fall = ~phi2_sync_q[1] & phi2_sync_q[2];

  // Bus qualifiers, captured while each strobe is active and dropped once it has been used.
  logic       wr_q;
  logic [7:0] wr_data_q;
  logic       rd_q;

  always_ff @(posedge clk or negedge rst_b_q) begin
    if (!rst_b_q) begin
      wr_q      <= 1'b0;
      wr_data_q <= 8'h00;
      rd_q      <= 1'b0;
    end else if (fifo_clr) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      if (!p_wr_sync_q[1]) begin
        wr_q      <= !p_cs_b && (p_addr == RegPh1);
        wr_data_q <= p_data;
      end else if (p_wr_rise) begin
        wr_q <= 1'b0;
      end
      if (phi2_sync_q[1]) begin
        rd_q <= !h_cs_b && h_rdnw && (h_addr == RegPh1);
      end else if (phi2_fall) begin
        rd_q <= 1'b0;
      end
    end
  end

  // Push/pop acceptance.
  logic push_req, pop_req, push_ok, pop_ok;

  assign push_req = p_wr_rise & wr_q & ~fifo_clr;
  assign pop_req  = phi2_fall & rd_q & ~fifo_clr;
  assign pop_ok   = pop_req & (ph1_count != '0);
  assign push_ok  = push_req & ((ph1_count != FullCnt) | pop_ok);

  // Storage
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          ovf_q, ovf_d;
  logic          avail_q, space_q;
  logic [PW-1:0] rd_next;

  assign rd_next = ptr_inc(rd_ptr_q);

  // NOTE: the data array carries no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data_q;
  end

  // NOTE: every next-state signal is defaulted first so no path through the block infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    ovf_d    = ovf_q;

    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = 8'h00;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = rd_next;

      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // The pushed byte becomes the head if nothing older will remain after this cycle.
      if (push_ok && (count_q == '0 || (pop_ok && count_q == PW'(1)))) begin
        head_d = wr_data_q;
      end else if (pop_ok && count_q > PW'(1)) begin
        head_d = mem[rd_next];
      end

      if (push_req && !push_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b_q) begin
    if (!rst_b_q) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= 8'h00;
      ovf_q    <= 1'b0;
      avail_q  <= 1'b0;
      space_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
      avail_q  <= (count_d != '0);
      space_q  <= (count_d != FullCnt);
    end
  end

  assign h_rd_data = head_q;
  assign ph1_count = count_q;
  assign ph1_avail = avail_q;
  assign ph1_space = space_q;
  assign ph1_ovf   = ovf_q;

endmodule

// File: tb/tb_tube_ph1_fifo.sv
`timescale 1ns/1ps
// Directed bench for tube_ph1_fifo: parasite writes and host reads driven as bus cycles,
// with hand-computed expected bytes, counts and flags.
module tb_tube_ph1_fifo;

  localparam int DEPTH = 24;
  localparam int PW    = 5;

  logic          clk = 1'b0;
  logic          h_rst_b;
  logic          fifo_clr;
  logic          p_cs_b, p_wr_b;
  logic [2:0]    p_addr;
  logic [7:0]    p_data;
  logic          h_phi2, h_cs_b, h_rdnw;
  logic [2:0]    h_addr;
  logic [7:0]    h_rd_data;
  logic          ph1_avail, ph1_space, ph1_ovf;
  logic [PW-1:0] ph1_count;

  int checks = 0;
  int errors = 0;

  tube_ph1_fifo #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk       (clk),
    .h_rst_b   (h_rst_b),
    .fifo_clr  (fifo_clr),
    .p_cs_b    (p_cs_b),
    .p_wr_b    (p_wr_b),
    .p_addr    (p_addr),
    .p_data    (p_data),
    .h_phi2    (h_phi2),
    .h_cs_b    (h_cs_b),
    .h_rdnw    (h_rdnw),
    .h_addr    (h_addr),
    .h_rd_data (h_rd_data),
    .ph1_avail (ph1_avail),
    .ph1_space (ph1_space),
    .ph1_count (ph1_count),
    .ph1_ovf   (ph1_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Parasite write cycle: strobe low 4 clk, data held 4 clk past the rising edge.
  task automatic par_write(input logic [2:0] addr, input logic [7:0] data);
    p_cs_b = 1'b0; p_addr = addr; p_data = data; p_wr_b = 1'b0;
    wait_clk(4);
    p_wr_b = 1'b1;
    wait_clk(4);
    p_cs_b = 1'b1;
    wait_clk(2);
  endtask

  // Host read cycle at 16 clk per phi2 period; data sampled late in phi2-high.
  task automatic host_read(input logic [2:0] addr, output logic [7:0] data);
    h_cs_b = 1'b0; h_rdnw = 1'b1; h_addr = addr; h_phi2 = 1'b1;
    wait_clk(8);
    data = h_rd_data;
    h_phi2 = 1'b0;
    wait_clk(8);
    h_cs_b = 1'b1;
    wait_clk(1);
  endtask

  logic [7:0] rdata;

  initial begin
    h_rst_b = 1'b0; fifo_clr = 1'b0;
    p_cs_b = 1'b1; p_wr_b = 1'b1; p_addr = 3'd0; p_data = 8'h00;
    h_phi2 = 1'b0; h_cs_b = 1'b1; h_rdnw = 1'b1; h_addr = 3'd0;
    wait_clk(3);
    h_rst_b = 1'b1;
    wait_clk(4);

    check("reset_count", ph1_count, 0);
    check("reset_avail", ph1_avail, 0);
    check("reset_space", ph1_space, 1);
    check("reset_head",  h_rd_data, 8'h00);
    check("reset_ovf",   ph1_ovf,   0);

    // Three bytes in, three out, in order.
    par_write(3'd1, 8'h11);
    par_write(3'd1, 8'h22);
    par_write(3'd1, 8'h33);
    check("three_count", ph1_count, 3);
    check("three_head",  h_rd_data, 8'h11);
    check("three_avail", ph1_avail, 1);
    host_read(3'd1, rdata); check("read1", rdata, 8'h11);
    check("read1_head", h_rd_data, 8'h22);
    host_read(3'd1, rdata); check("read2", rdata, 8'h22);
    check("read2_avail", ph1_avail, 1);
    host_read(3'd1, rdata); check("read3", rdata, 8'h33);
    check("read3_avail", ph1_avail, 0);
    check("read3_count", ph1_count, 0);

    // Read while empty and wrong-address accesses.
    host_read(3'd1, rdata); check("empty_read_data", rdata, 8'h33);
    check("empty_read_count", ph1_count, 0);
    check("empty_read_head",  h_rd_data, 8'h33);
    check("empty_read_ovf",   ph1_ovf,   0);
    par_write(3'd3, 8'h44);
    check("addr3_write_count", ph1_count, 0);
    par_write(3'd1, 8'h55);
    check("one_count", ph1_count, 1);
    check("one_head",  h_rd_data, 8'h55);
    host_read(3'd0, rdata);
    check("addr0_read_count", ph1_count, 1);
    host_read(3'd1, rdata); check("read_55", rdata, 8'h55);
    check("read_55_count", ph1_count, 0);

    // Fill to full, overflow, drain; then three more wrapping fill/drain passes.
    for (int i = 0; i < DEPTH; i++) par_write(3'd1, 8'(i));
    check("full_count", ph1_count, DEPTH);
    check("full_space", ph1_space, 0);
    check("full_head",  h_rd_data, 8'h00);
    par_write(3'd1, 8'hAA);
    check("ovf_flag",  ph1_ovf,   1);
    check("ovf_count", ph1_count, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      host_read(3'd1, rdata);
      check("drain0", rdata, 8'(i));
    end
    check("drain0_count", ph1_count, 0);
    check("drain0_ovf_sticky", ph1_ovf, 1);
    for (int c = 1; c <= 3; c++) begin
      for (int i = 0; i < DEPTH; i++) par_write(3'd1, 8'(c * 32 + i));
      check("wrap_full_count", ph1_count, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
        host_read(3'd1, rdata);
        check("wrap_drain", rdata, 8'(c * 32 + i));
      end
      check("wrap_empty_avail", ph1_avail, 0);
    end

    // Clear the sticky overflow before the simultaneous push/pop case.
    fifo_clr = 1'b1;
    wait_clk(2);
    fifo_clr = 1'b0;
    wait_clk(1);
    check("clr1_ovf", ph1_ovf, 0);

    for (int i = 0; i < DEPTH; i++) par_write(3'd1, 8'(8'h80 + i));
    check("sim_full_count", ph1_count, DEPTH);
    h_cs_b = 1'b0; h_rdnw = 1'b1; h_addr = 3'd1; h_phi2 = 1'b1;
    p_cs_b = 1'b0; p_addr = 3'd1; p_data = 8'h5A; p_wr_b = 1'b0;
    wait_clk(8);
    rdata = h_rd_data;
    h_phi2 = 1'b0; p_wr_b = 1'b1;
    wait_clk(8);
    h_cs_b = 1'b1; p_cs_b = 1'b1;
    wait_clk(1);
    check("sim_read", rdata, 8'h80);
    check("sim_count", ph1_count, DEPTH);
    check("sim_ovf",   ph1_ovf,   0);
    check("sim_head",  h_rd_data, 8'h81);
    for (int i = 1; i < DEPTH; i++) begin
      host_read(3'd1, rdata);
      check("sim_drain", rdata, 8'(8'h80 + i));
    end
    host_read(3'd1, rdata); check("sim_last_5a", rdata, 8'h5A);
    check("sim_empty_count", ph1_count, 0);

    // fifo_clr with data present, then a fresh write.
    for (int i = 0; i < 10; i++) par_write(3'd1, 8'(8'h60 + i));
    check("ten_count", ph1_count, 10);
    fifo_clr = 1'b1;
    wait_clk(2);
    fifo_clr = 1'b0;
    wait_clk(1);
    check("clr_count", ph1_count, 0);
    check("clr_ovf",   ph1_ovf,   0);
    check("clr_head",  h_rd_data, 8'h00);
    check("clr_avail", ph1_avail, 0);
    check("clr_space", ph1_space, 1);
    par_write(3'd1, 8'h77);
    check("post_clr_head",  h_rd_data, 8'h77);
    check("post_clr_count", ph1_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
